// File: rtl/comp_mul_seq_if.sv
// Handshake/data bundle for comp_mul_seq.
//   master: request side. Drives operands a_r/a_i/b_r/b_i, i_en, i_conj, i_acc;
//           observes i_rdy and the result o_r/o_i/o_en.
//   slave:  the multiplier itself, the mirror image of master.
// OW = 2*W + 1 + GUARD is the signed width of the (accumulated) result.
interface comp_mul_seq_if #(
  parameter int W     = 8,
  parameter int GUARD = 4
);
  localparam int OW = 2*W + 1 + GUARD;

  logic signed [W-1:0]  a_r;
  logic signed [W-1:0]  a_i;
  logic signed [W-1:0]  b_r;
  logic signed [W-1:0]  b_i;
  logic                 i_en;
  logic                 i_conj;
  logic                 i_acc;
  logic                 i_rdy;
  logic signed [OW-1:0] o_r;
  logic signed [OW-1:0] o_i;
  logic                 o_en;

  modport master (
    output a_r, a_i, b_r, b_i, i_en, i_conj, i_acc,
    input  i_rdy, o_r, o_i, o_en
  );

  modport slave (
    input  a_r, a_i, b_r, b_i, i_en, i_conj, i_acc,
    output i_rdy, o_r, o_i, o_en
  );
endinterface

// File: rtl/comp_mul_seq.sv
// Serial complex multiplier / MAC. One complex product (A * B or A * conj(B))
// per 5 cycles through a single shared W x W signed multiplier; optionally
// accumulated onto the previous o_r/o_i (wraps modulo 2^OW).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - comp_mul_seq_if.slave: operands + i_en/i_conj/i_acc in,
//          i_rdy and o_r/o_i/o_en out
// GUARD must be at least 1.
//
// state | meaning
// IDLE  | waiting for a request, i_rdy=1
// RR    | pp1 <= a_r*b_r
// II    | pp2 <= a_i*b_i
// RI    | re formed from pp1/pp2; pp1 <= a_r*b_i
// IR    | pp2 <= a_i*b_r
// OUT   | im formed, result written, o_en next cycle; i_rdy=1 (back-to-back)
module comp_mul_seq #(
  parameter int W     = 8,
  parameter int GUARD = 4
) (
  input  logic          clk,
  input  logic          rst,
  comp_mul_seq_if.slave bus
);
  localparam int PW = 2*W;
  localparam int SW = 2*W + 1;
  localparam int OW = SW + GUARD;

  typedef enum logic [2:0] {S_IDLE, S_RR, S_II, S_RI, S_IR, S_OUT} state_t;

  state_t state, state_nx;

  logic signed [W-1:0]  ar_q, ai_q, br_q, bi_q;
  logic                 conj_q, acc_q;
  logic signed [W-1:0]  mul_a, mul_b;
  logic signed [PW-1:0] mul_p;
  logic signed [PW-1:0] pp1, pp2;
  logic signed [SW-1:0] pp1_x, pp2_x;
  logic signed [SW-1:0] re_q, re_nx, im_nx;
  logic signed [OW-1:0] o_r_q, o_i_q;
  logic                 o_en_q;
  logic                 rdy;
  logic                 accept;

  assign rdy    = (state == S_IDLE) || (state == S_OUT);
  assign accept = bus.i_en && rdy;

  assign bus.i_rdy = rdy;
  assign bus.o_r   = o_r_q;
  assign bus.o_i   = o_i_q;
  assign bus.o_en  = o_en_q;

  // Shared multiplier operand select; conjugation is applied in the sums,
  // never by negating b_i, so -2^(W-1) operands stay exact.
  always_comb begin
    mul_a = ar_q;
    mul_b = br_q;
    case (state)
      S_II:    begin mul_a = ai_q; mul_b = bi_q; end
      S_RI:    begin mul_a = ar_q; mul_b = bi_q; end
      S_IR:    begin mul_a = ai_q; mul_b = br_q; end
      default: begin mul_a = ar_q; mul_b = br_q; end
    endcase
  end

  assign mul_p = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});

  assign pp1_x = {pp1[PW-1], pp1};
  assign pp2_x = {pp2[PW-1], pp2};
  // In RI: pp1 = a_r*b_r, pp2 = a_i*b_i. In OUT: pp1 = a_r*b_i, pp2 = a_i*b_r.
  assign re_nx = conj_q ? (pp1_x + pp2_x) : (pp1_x - pp2_x);
  assign im_nx = conj_q ? (pp2_x - pp1_x) : (pp2_x + pp1_x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RR;
      S_RR:    state_nx = S_II;
      S_II:    state_nx = S_RI;
      S_RI:    state_nx = S_IR;
      S_IR:    state_nx = S_OUT;
      S_OUT:   state_nx = accept ? S_RR : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q   <= '0;
      ai_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      conj_q <= 1'b0;
      acc_q  <= 1'b0;
      pp1    <= '0;
      pp2    <= '0;
      re_q   <= '0;
      o_r_q  <= '0;
      o_i_q  <= '0;
      o_en_q <= 1'b0;
    end else begin
      o_en_q <= 1'b0;
      if (accept) begin
        ar_q   <= bus.a_r;
        ai_q   <= bus.a_i;
        br_q   <= bus.b_r;
        bi_q   <= bus.b_i;
        conj_q <= bus.i_conj;
        acc_q  <= bus.i_acc;
      end
      case (state)
        S_RR: pp1 <= mul_p;
        S_II: pp2 <= mul_p;
        S_RI: begin
          re_q <= re_nx;
          pp1  <= mul_p;
        end
        S_IR: pp2 <= mul_p;
        S_OUT: begin
          // acc_q still belongs to the finishing operation even if a new
          // request is latched on this same edge.
          o_r_q  <= (acc_q ? o_r_q : '0) + {{GUARD{re_q[SW-1]}}, re_q};
          o_i_q  <= (acc_q ? o_i_q : '0) + {{GUARD{im_nx[SW-1]}}, im_nx};
          o_en_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_mul_seq.sv
module tb_comp_mul_seq;
  localparam int W     = 8;
  localparam int GUARD = 4;
  localparam int OW    = 2*W + 1 + GUARD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  int er4 [3] = '{-7, 5, -50};
  int ei4 [3] = '{22, 10, 41};
  int nacc, nres, last_c, saw;
  logic signed [OW-1:0] exp_i;

  comp_mul_seq_if #(.W(W), .GUARD(GUARD)) bus ();
  comp_mul_seq #(.W(W), .GUARD(GUARD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi, input bit conj, input bit acc);
    bus.a_r    = 8'(ar);
    bus.a_i    = 8'(ai);
    bus.b_r    = 8'(br);
    bus.b_i    = 8'(bi);
    bus.i_conj = conj;
    bus.i_acc  = acc;
  endtask

  // Called at a negedge; returns at the negedge after the o_en pulse.
  task automatic do_op(input string tag, input int ar, input int ai, input int br, input int bi,
                       input bit conj, input bit acc, input logic signed [63:0] er, input logic signed [63:0] ei);
    int cyc;
    int rdy_low;
    cyc = 0;
    while (!bus.i_rdy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".rdy_wait"}, bus.i_rdy, 1);
    drive(ar, ai, br, bi, conj, acc);
    bus.i_en = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0;
    cyc = 0;
    rdy_low = bus.i_rdy ? 0 : 1;
    while (!bus.o_en && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (!bus.i_rdy) rdy_low++;
    end
    check({tag, ".lat"}, cyc, 5);
    check({tag, ".rdy_low"}, rdy_low, 4);
    check({tag, ".o_r"}, bus.o_r, er);
    check({tag, ".o_i"}, bus.o_i, ei);
    @(negedge clk);
    check({tag, ".o_en_pulse"}, bus.o_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_en = 1'b1;
    drive(3, 4, 5, -2, 0, 0);
    @(negedge clk);
    check("rst.i_rdy", bus.i_rdy, 1);
    check("rst.o_en", bus.o_en, 0);
    check("rst.o_r", bus.o_r, 0);
    check("rst.o_i", bus.o_i, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst.ign_en", bus.o_en, 0);
    bus.i_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rel.i_rdy", bus.i_rdy, 1);

    // 1: basic product
    do_op("t1", 3, 4, 5, -2, 0, 0, 23, 14);

    // 2: extremes
    do_op("t2a", -128, -128, -128, -128, 0, 0, 0, 32768);
    do_op("t2b", -128, -128, -128, -128, 1, 0, 32768, 0);

    // 3: accumulate sequence
    do_op("t3a", 1, 1, 1, 1, 0, 0, 0, 2);
    do_op("t3b", 2, 0, 3, 0, 0, 1, 6, 2);
    do_op("t3c", 1, 0, 1, 0, 0, 0, 1, 0);

    // 4: back-to-back with i_en held, junk operands while busy
    nacc = 0;
    nres = 0;
    last_c = -1;
    for (int c = 0; c < 60 && nres < 3; c++) begin
      if (bus.o_en) begin
        check($sformatf("t4.o_r%0d", nres), bus.o_r, er4[nres]);
        check($sformatf("t4.o_i%0d", nres), bus.o_i, ei4[nres]);
        if (last_c >= 0) check($sformatf("t4.gap%0d", nres), c - last_c, 5);
        last_c = c;
        nres++;
      end
      if (bus.i_rdy && nacc < 3) begin
        case (nacc)
          0:       drive(2, 3, 4, 5, 0, 0);
          1:       drive(-1, 2, 3, -4, 0, 0);
          default: drive(7, -8, -6, 1, 1, 0);
        endcase
        bus.i_en = 1'b1;
        nacc++;
      end else if (bus.i_rdy) begin
        bus.i_en = 1'b0;
      end else begin
        drive(127, -128, -128, 127, 1, 1);
      end
      @(negedge clk);
    end
    bus.i_en = 1'b0;
    check("t4.count", nres, 3);

    // 5: reset during RI
    drive(1, 2, 3, 4, 0, 0);
    bus.i_en = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5.hold_r", bus.o_r, -50);
    rst = 1'b1;
    #1;
    check("t5.o_r", bus.o_r, 0);
    check("t5.o_i", bus.o_i, 0);
    check("t5.i_rdy", bus.i_rdy, 1);
    check("t5.o_en", bus.o_en, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_en) saw = 1;
    end
    check("t5.no_o_en", saw, 0);
    do_op("t5b", 1, 2, 3, 4, 0, 0, -5, 10);

    // 6: accumulator wrap
    do_op("t6.zero", 0, 0, 0, 0, 0, 0, 0, 0);
    exp_i = '0;
    for (int n = 1; n <= 32; n++) begin
      exp_i = exp_i + 21'sd32768;
      do_op($sformatf("t6.s%0d", n), -128, -128, -128, -128, 0, 1, 0, exp_i);
    end
    check("t6.final_i", bus.o_i, -1048576);
    check("t6.final_r", bus.o_r, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comp_mul_seq.md
Name: comp_mul_seq

Overview:
- Parametrised successor to the team's serial 8-bit complex multiplier.
- Computes one complex product (a_r + j·a_i)·(b_r + j·b_i) with a single shared signed multiplier over 5 cycles.
- Adds generic width, an input ready handshake, a per-operation conjugate-b mode and a per-operation accumulate mode (complex MAC).
- Sits between sample sources and downstream filter/correlator logic.

Parameters:
W, 8, signed operand width of each real/imag input
GUARD, 4, accumulator guard bits; output width OW = 2*W + 1 + GUARD

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
a_r  in  W  operand A real, signed
a_i  in  W  operand A imag, signed
b_r  in  W  operand B real, signed
b_i  in  W  operand B imag, signed
i_en  in  1  request; accepted only when i_rdy=1
i_conj  in  1  sampled with operands; 1 = use conj(B)
i_acc  in  1  sampled with operands; 1 = add product to current o_r/o_i
i_rdy  out  1  block can accept a request this cycle
o_r  out  OW  result real, signed
o_i  out  OW  result imag, signed
o_en  out  1  one-cycle pulse, o_r/o_i updated this cycle

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - o_r, o_i, o_en and all internal partial-product/operand registers go to 0.
  - i_rdy reads 1 while in IDLE, including during reset.
  - i_en is ignored while rst=1.
- Handshake:
  - Accept on a rising edge where i_en=1 and i_rdy=1.
  - On accept, latch a_r, a_i, b_r, b_i, i_conj and i_acc.
  - i_en with i_rdy=0 is ignored; latched operands must not change mid-operation.
- i_rdy = 1 in IDLE and OUT, 0 otherwise.
- States and per-cycle work (mul = single W×W signed multiplier, 2W-bit result):
  - IDLE: accept → RR; else stay.
  - RR: pp1 <= a_r*b_r → II.
  - II: pp2 <= a_i*b_i → RI.
  - RI: re <= conj ? pp1+pp2 : pp1-pp2 (2W+1 bits); pp1 <= a_r*b_i → IR.
  - IR: pp2 <= a_i*b_r → OUT.
  - OUT: im = conj ? pp2-pp1 : pp2+pp1.
    - o_r <= (acc ? o_r : 0) + sext(re); o_i <= (acc ? o_i : 0) + sext(im); o_en <= 1.
    - If a new request is accepted this cycle → RR, else → IDLE.
- Latency: accept at edge k → o_en high and new o_r/o_i visible after edge k+5. Back-to-back throughput is 1 result per 5 cycles.
- o_en is high for exactly one cycle per accepted request; otherwise 0.
- o_r/o_i hold their value between results.
- Arithmetic: all signed two's complement; operands sign-extended to OW before addition.
- Accumulation wraps modulo 2^OW; no saturation.
- A non-acc result discards the previous accumulator contents.
- Extremes with W=8: (-128)·(-128) = 16384 in 2W bits. Sums are formed at 2W+1 bits, so |re|,|im| ≤ 32768 are exact.
- Reset mid-operation: operation abandoned, no o_en, outputs 0, IDLE on release.
- Simultaneous accept in OUT: the current result is written and the new operands are latched on the same edge. The new request's i_acc uses the value just written.

Test Plan:
1. W=8, GUARD=4 (OW=21): i_en pulse with (3+4j)·(5-2j), conj=0, acc=0 → i_rdy low 4 cycles; o_en pulse 5 cycles after accept; o_r=23, o_i=14.
2. Extremes: (-128-128j)·(-128-128j), conj=0 → o_r=0, o_i=32768. Same operands with conj=1 → o_r=32768, o_i=0.
3. Accumulate sequence:
   - (1+1j)·(1+1j), acc=0 → 0+2j.
   - Then (2+0j)·(3+0j), acc=1 → 6+2j.
   - Then (1+0j)·(1+0j), acc=0 → 1+0j.
4. Back-to-back and busy rejection:
   - Hold i_en=1 with a new operand set each accept → o_en pulses exactly 5 cycles apart, each with the correct product.
   - Operands changed while i_rdy=0 do not corrupt the in-flight result.
5. Reset mid-operation: assert rst during the RI cycle → o_r=o_i=0 immediately, no o_en pulse, i_rdy=1. The next request after release completes normally.
6. Accumulator wrap: 32 consecutive acc=1 requests of (-128-128j)², starting from an acc=0 zero product → o_i steps by 32768 and wraps to -1048576 on the 32nd; o_r stays 0.
